// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, branch flush and a saturating bubble counter.
// Latency: one cycle from ID to EX when there is no flush, stall or load-use hazard.
// Backpressure: ex_stall freezes EX and raises id_hold; a load-use hazard raises id_hold and inserts one bubble.
//
// Ports:
//   clk, rst               clock (posedge) and asynchronous active-high reset
//   id_*                   decoded instruction, RF read data, immediate and control from ID
//   ex_flush               taken branch/jump resolved in EX; kills the ID instruction
//   ex_stall               downstream cannot accept; EX contents hold
//   ex_*                   registered instruction presented to EX
//   id_hold                combinational freeze request for the PC and IF/ID
//   bubble_cnt             saturating count of load-use bubbles inserted
module id_ex_stage #(
    parameter int DW   = 32,
    parameter int AW   = 5,
    parameter int CW   = 16,
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    input  logic [DW-1:0]   id_pc,
    input  logic [AW-1:0]   id_rs1,
    input  logic [AW-1:0]   id_rs2,
    input  logic            id_use_rs1,
    input  logic            id_use_rs2,
    input  logic [AW-1:0]   id_rd,
    input  logic [DW-1:0]   id_rd1,
    input  logic [DW-1:0]   id_rd2,
    input  logic [DW-1:0]   id_imm,
    input  logic [CW-1:0]   id_ctrl,
    input  logic            id_mem_read,
    input  logic            id_rf_wr,
    input  logic            ex_flush,
    input  logic            ex_stall,
    output logic            ex_valid,
    output logic [DW-1:0]   ex_pc,
    output logic [DW-1:0]   ex_op1,
    output logic [DW-1:0]   ex_op2,
    output logic [DW-1:0]   ex_imm,
    output logic [AW-1:0]   ex_rs1,
    output logic [AW-1:0]   ex_rs2,
    output logic [AW-1:0]   ex_rd,
    output logic [CW-1:0]   ex_ctrl,
    output logic            ex_mem_read,
    output logic            ex_rf_wr,
    output logic            id_hold,
    output logic [CNTW-1:0] bubble_cnt
);

    logic rs1Hit;
    logic rs2Hit;
    logic loadUse;
    logic doBubble;

    // The load in EX produces its data only after MEM, so a consumer in ID
    // must wait one cycle; MEM/WB forwarding covers it after that. x0 is
    // hardwired so a load targeting it never creates a dependency.
    assign rs1Hit  = id_use_rs1 & (id_rs1 == ex_rd);
    assign rs2Hit  = id_use_rs2 & (id_rs2 == ex_rd);
    assign loadUse = ex_valid & ex_mem_read & (ex_rd != '0) & id_valid & (rs1Hit | rs2Hit);

    // A flush kills the ID instruction anyway, so a hazard on it needs no hold.
    assign id_hold  = ex_stall | (loadUse & ~ex_flush);
    assign doBubble = ~ex_flush & ~ex_stall & loadUse;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid    <= 1'b0;
            ex_mem_read <= 1'b0;
            ex_rf_wr    <= 1'b0;
            ex_pc       <= '0;
            ex_op1      <= '0;
            ex_op2      <= '0;
            ex_imm      <= '0;
            ex_rs1      <= '0;
            ex_rs2      <= '0;
            ex_rd       <= '0;
            ex_ctrl     <= '0;
        end else if (ex_flush) begin
            // Flush wins over stall: the EX slot becomes an empty bubble.
            ex_valid    <= 1'b0;
            ex_mem_read <= 1'b0;
            ex_rf_wr    <= 1'b0;
            ex_pc       <= '0;
            ex_op1      <= '0;
            ex_op2      <= '0;
            ex_imm      <= '0;
            ex_rs1      <= '0;
            ex_rs2      <= '0;
            ex_rd       <= '0;
            ex_ctrl     <= '0;
        end else if (ex_stall) begin
            ex_valid    <= ex_valid;
        end else if (loadUse) begin
            // Bubble: only the qualifiers are cleared, payload is don't-care.
            ex_valid    <= 1'b0;
            ex_mem_read <= 1'b0;
            ex_rf_wr    <= 1'b0;
        end else begin
            ex_valid    <= id_valid;
            ex_mem_read <= id_mem_read & id_valid;
            ex_rf_wr    <= id_rf_wr & id_valid;
            ex_pc       <= id_pc;
            ex_op1      <= id_rd1;
            ex_op2      <= id_rd2;
            ex_imm      <= id_imm;
            ex_rs1      <= id_rs1;
            ex_rs2      <= id_rs2;
            ex_rd       <= id_rd;
            ex_ctrl     <= id_ctrl;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bubble_cnt <= '0;
        end else if (doBubble && (bubble_cnt != '1)) begin
            bubble_cnt <= bubble_cnt + {{(CNTW-1){1'b0}}, 1'b1};
        end
    end

endmodule
